// File: rtl/io_clk_p.sv
// Shared definitions for the serial frame receive path: default geometry,
// receiver state encoding and small combinational helpers.
package io_clk_p;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_FIFO_DEPTH = 4;
    localparam int RX_STATE_WIDTH     = 3;

    typedef enum logic [RX_STATE_WIDTH-1:0] {
        ST_UNSYNCED   = 3'd0,
        ST_IDLE       = 3'd1,
        ST_RECEIVE    = 3'd2,
        ST_PAUSE_WAIT = 3'd3,
        ST_WORD_HELD  = 3'd4,
        ST_ERROR      = 3'd5
    } rx_state_t;

    // Any clock-recovery violation flag aborts the word in progress.
    function automatic logic any_violation(input logic overflow_v,
                                           input logic underflow_v,
                                           input logic frequency_v);
        return overflow_v | underflow_v | frequency_v;
    endfunction

endpackage

// File: rtl/rx_word_fifo.sv
// Word buffer between the deserializer and its consumer. Stores {last, data}
// entries; a push into a full buffer is accepted only if the head is popped in
// the same cycle, otherwise the word is discarded and a sticky flag is raised.
module rx_word_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             sync_rst_n,
    input  logic             clk_en,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             dropped_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             dropped_q, dropped_d;
    logic             full_s, empty_s, push_s, pop_s, drop_s;

    assign full_s      = (count_q == CW'(DEPTH));
    assign empty_s     = (count_q == {CW{1'b0}});
    assign in_ready_o  = !full_s || out_ready_i;
    assign out_valid_o = !empty_s;
    assign out_data_o  = mem_q[rd_ptr_q];
    assign dropped_o   = dropped_q;

    assign pop_s  = clk_en && !empty_s && out_ready_i;
    assign push_s = clk_en && in_valid_i && in_ready_o;
    assign drop_s = clk_en && in_valid_i && !in_ready_o;

    // Pointer, occupancy and drop-flag next-state; pointers wrap naturally.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        dropped_d = dropped_q | drop_s;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Buffer storage and control registers, cleared by reset, gated by clk_en.
    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q  <= {AW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            count_q   <= {CW{1'b0}};
            dropped_q <= 1'b0;
        end else if (clk_en) begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= in_data_i;
            end
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            dropped_q <= dropped_d;
        end
    end

endmodule

// File: rtl/frame_deserializer.sv
// Serial-to-parallel frame receiver. Bits arrive MSB first on sample ticks,
// words are delimited by short pauses and frames by long pauses. Completed
// words are registered for one cycle and then written into rx_word_fifo.
module frame_deserializer
    import io_clk_p::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH    = DEFAULT_FIFO_DEPTH,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     sync_rst_n,
    input  logic                     clk_en,
    input  logic                     recovery_enable_i,
    input  logic                     data_i,
    input  logic                     tick_input_i,
    input  logic                     pause_start_detected_i,
    input  logic                     short_pause_complete_i,
    input  logic                     long_pause_complete_i,
    input  logic                     data_overflow_violation_i,
    input  logic                     data_underflow_violation_i,
    input  logic                     frequency_violation_i,
    output logic                     word_valid_o,
    input  logic                     word_ready_i,
    output logic [DATA_WIDTH-1:0]    word_data_o,
    output logic                     word_last_o,
    output logic                     word_dropped_o,
    output logic [ERR_CNT_WIDTH-1:0] frame_error_count_o,
    output logic [2:0]               rx_state_o
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);

    rx_state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0]    shift_q, shift_d;
    logic [BCW-1:0]           bit_cnt_q, bit_cnt_d;
    logic                     push_q, push_d;
    logic [DATA_WIDTH:0]      push_word_q, push_word_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                     viol_s, bit_full_s;
    logic [DATA_WIDTH-1:0]    first_bit_s;
    logic [DATA_WIDTH:0]      fifo_head_s;
    logic                     fifo_in_ready_s;

    assign viol_s      = any_violation(data_overflow_violation_i,
                                       data_underflow_violation_i,
                                       frequency_violation_i);
    assign bit_full_s  = (bit_cnt_q == BCW'(DATA_WIDTH));
    assign first_bit_s = {{(DATA_WIDTH-1){1'b0}}, data_i};

    // State register: reset wins over clk_en, state advances only when enabled.
    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            state_q <= ST_UNSYNCED;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    // Next-state logic; violations take priority over tick and pause events.
    always_comb begin
        state_d = state_q;
        if (!recovery_enable_i) begin
            state_d = ST_UNSYNCED;
        end else begin
            case (state_q)
                ST_UNSYNCED: begin
                    if (long_pause_complete_i) state_d = ST_IDLE;
                    else                       state_d = state_q;
                end
                ST_IDLE: begin
                    if (tick_input_i) state_d = ST_RECEIVE;
                    else              state_d = state_q;
                end
                ST_RECEIVE: begin
                    if (viol_s)                      state_d = ST_ERROR;
                    else if (tick_input_i)           state_d = bit_full_s ? ST_ERROR : ST_RECEIVE;
                    else if (pause_start_detected_i) state_d = bit_full_s ? ST_PAUSE_WAIT : ST_ERROR;
                    else                             state_d = state_q;
                end
                ST_PAUSE_WAIT: begin
                    if (viol_s)                      state_d = ST_ERROR;
                    else if (tick_input_i)           state_d = ST_ERROR;
                    else if (short_pause_complete_i) state_d = ST_WORD_HELD;
                    else                             state_d = state_q;
                end
                ST_WORD_HELD: begin
                    if (viol_s)                     state_d = ST_ERROR;
                    else if (tick_input_i)          state_d = ST_RECEIVE;
                    else if (long_pause_complete_i) state_d = ST_IDLE;
                    else                            state_d = state_q;
                end
                ST_ERROR: begin
                    if (long_pause_complete_i) state_d = ST_IDLE;
                    else                       state_d = state_q;
                end
                default: state_d = ST_UNSYNCED;
            endcase
        end
    end

    // Datapath outputs of the FSM: shift register, bit count, push request, error count.
    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        push_d      = 1'b0;
        push_word_d = push_word_q;
        err_cnt_d   = err_cnt_q;
        if (!recovery_enable_i || (state_d == ST_ERROR)) begin
            shift_d   = {DATA_WIDTH{1'b0}};
            bit_cnt_d = {BCW{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tick_input_i) begin
                        shift_d   = first_bit_s;
                        bit_cnt_d = BCW'(1);
                    end else begin
                        shift_d   = shift_q;
                    end
                end
                ST_RECEIVE: begin
                    if (tick_input_i) begin
                        shift_d   = {shift_q[DATA_WIDTH-2:0], data_i};
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end else begin
                        shift_d   = shift_q;
                    end
                end
                ST_WORD_HELD: begin
                    if (tick_input_i) begin
                        push_d      = 1'b1;
                        push_word_d = {1'b0, shift_q};
                        shift_d     = first_bit_s;
                        bit_cnt_d   = BCW'(1);
                    end else if (long_pause_complete_i) begin
                        push_d      = 1'b1;
                        push_word_d = {1'b1, shift_q};
                        shift_d     = {DATA_WIDTH{1'b0}};
                        bit_cnt_d   = {BCW{1'b0}};
                    end else begin
                        shift_d     = shift_q;
                    end
                end
                default: begin
                    shift_d = shift_q;
                end
            endcase
        end
        if ((state_d == ST_ERROR) && (state_q != ST_ERROR) &&
            (err_cnt_q != {ERR_CNT_WIDTH{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Datapath registers; the push request is held one cycle before the buffer write.
    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            shift_q     <= {DATA_WIDTH{1'b0}};
            bit_cnt_q   <= {BCW{1'b0}};
            push_q      <= 1'b0;
            push_word_q <= {(DATA_WIDTH+1){1'b0}};
            err_cnt_q   <= {ERR_CNT_WIDTH{1'b0}};
        end else if (clk_en) begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            push_q      <= push_d;
            push_word_q <= push_word_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    rx_word_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_word_fifo (
        .clk         (clk),
        .sync_rst_n  (sync_rst_n),
        .clk_en      (clk_en),
        .in_valid_i  (push_q),
        .in_ready_o  (fifo_in_ready_s),
        .in_data_i   (push_word_q),
        .out_valid_o (word_valid_o),
        .out_ready_i (word_ready_i),
        .out_data_o  (fifo_head_s),
        .dropped_o   (word_dropped_o)
    );

    assign word_data_o         = fifo_head_s[DATA_WIDTH-1:0];
    assign word_last_o         = fifo_head_s[DATA_WIDTH];
    assign frame_error_count_o = err_cnt_q;
    assign rx_state_o          = state_q;

    // The buffer's ready only matters to the buffer itself; a refused push is
    // recorded there as a drop.
    logic unused_s;
    assign unused_s = fifo_in_ready_s;

endmodule

// File: tb/tb_frame_deserializer.sv
// Directed bench for frame_deserializer with a scoreboard: expected words are
// queued when the bench issues the pushing event and a monitor compares them
// as the DUT hands words over.
module tb_frame_deserializer;
    import io_clk_p::*;

    localparam int DW = 8;
    localparam int FD = 4;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          sync_rst_n = 1'b0;
    logic          clk_en = 1'b1;
    logic          rec_en = 1'b1;
    logic          data_i = 1'b0;
    logic          tick = 1'b0;
    logic          pstart = 1'b0;
    logic          pshort = 1'b0;
    logic          plong = 1'b0;
    logic          ov = 1'b0;
    logic          uv = 1'b0;
    logic          fv = 1'b0;
    logic          word_ready = 1'b0;
    logic          word_valid;
    logic [DW-1:0] word_data;
    logic          word_last;
    logic          word_dropped;
    logic [EW-1:0] err_cnt;
    logic [2:0]    rx_state;

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW:0]   exp_q [$];
    logic [DW:0]   mon_exp;

    always #5 clk = ~clk;

    frame_deserializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .ERR_CNT_WIDTH(EW)) dut (
        .clk                        (clk),
        .sync_rst_n                 (sync_rst_n),
        .clk_en                     (clk_en),
        .recovery_enable_i          (rec_en),
        .data_i                     (data_i),
        .tick_input_i               (tick),
        .pause_start_detected_i     (pstart),
        .short_pause_complete_i     (pshort),
        .long_pause_complete_i      (plong),
        .data_overflow_violation_i  (ov),
        .data_underflow_violation_i (uv),
        .frequency_violation_i      (fv),
        .word_valid_o               (word_valid),
        .word_ready_i               (word_ready),
        .word_data_o                (word_data),
        .word_last_o                (word_last),
        .word_dropped_o             (word_dropped),
        .frame_error_count_o        (err_cnt),
        .rx_state_o                 (rx_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_tick(input logic b);
        data_i = b; tick = 1'b1;
        step();
        tick = 1'b0; data_i = 1'b0;
    endtask

    task automatic pause_start();
        pstart = 1'b1; step(); pstart = 1'b0;
    endtask

    task automatic short_pause();
        pshort = 1'b1; step(); pshort = 1'b0;
    endtask

    task automatic long_pause();
        plong = 1'b1; step(); plong = 1'b0;
    endtask

    task automatic send_bits(input logic [DW-1:0] w);
        for (int i = DW - 1; i >= 0; i--) send_tick(w[i]);
    endtask

    // One-word frame from IDLE; keep=1 queues the word as expected output.
    task automatic frame(input logic [DW-1:0] w, input bit keep);
        send_bits(w);
        pause_start();
        short_pause();
        if (keep) exp_q.push_back({1'b1, w});
        long_pause();
    endtask

    task automatic drain(input int max_cycles);
        int i;
        word_ready = 1'b1;
        i = 0;
        while ((exp_q.size() != 0 || word_valid) && i < max_cycles) begin
            step();
            i++;
        end
        check("drain_empty", exp_q.size(), 0);
        check("drain_valid_low", word_valid, 1'b0);
    endtask

    // Scoreboard monitor: compare each handed-over word against the queue head.
    always @(negedge clk) begin
        if (sync_rst_n && clk_en && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_word: got 0x%0h, expected no word", {word_last, word_data});
            end else begin
                mon_exp = exp_q.pop_front();
                check("word", {word_last, word_data}, mon_exp);
            end
        end
    end

    initial begin
        #1000000;
        n_err++;
        $display("FAIL timeout: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        // Reset state
        repeat (3) step();
        check("rst_state", rx_state, ST_UNSYNCED);
        check("rst_valid", word_valid, 1'b0);
        check("rst_data", word_data, 8'h00);
        check("rst_last", word_last, 1'b0);
        check("rst_dropped", word_dropped, 1'b0);
        check("rst_errcnt", err_cnt, 8'h00);
        sync_rst_n = 1'b1;
        step();

        // Two-word frame: 0xA5 (last=0), 0x3C (last=1), with push latency
        long_pause();
        check("sync_idle", rx_state, ST_IDLE);
        send_bits(8'hA5);
        pause_start();
        check("pause_wait", rx_state, ST_PAUSE_WAIT);
        short_pause();
        check("word_held", rx_state, ST_WORD_HELD);
        exp_q.push_back({1'b0, 8'hA5});
        send_tick(1'b0);
        check("lat_a5_cycle1", word_valid, 1'b0);
        send_tick(1'b0);
        check("lat_a5_cycle2", word_valid, 1'b1);
        for (int i = 5; i >= 0; i--) send_tick(((8'h3C >> i) & 8'h01) != 8'h00);
        pause_start();
        short_pause();
        exp_q.push_back({1'b1, 8'h3C});
        long_pause();
        check("lat_3c_cycle1_idle", rx_state, ST_IDLE);
        repeat (3) step();
        check("head_stable_data", word_data, 8'hA5);
        check("head_stable_last", word_last, 1'b0);
        drain(20);
        word_ready = 1'b0;

        // Underflow: 5 ticks then pause start
        for (int i = 0; i < 5; i++) send_tick(1'b1);
        pause_start();
        check("underflow_state", rx_state, ST_ERROR);
        check("underflow_cnt", err_cnt, 8'd1);
        repeat (3) step();
        check("underflow_nopush", word_valid, 1'b0);
        long_pause();
        check("err_to_idle", rx_state, ST_IDLE);

        // Overflow of the buffer with the consumer stalled
        frame(8'h11, 1'b1);
        frame(8'h22, 1'b1);
        frame(8'h33, 1'b1);
        frame(8'h44, 1'b1);
        frame(8'h55, 1'b0);
        repeat (3) step();
        check("dropped_set", word_dropped, 1'b1);
        check("full_head", word_data, 8'h11);
        drain(20);
        word_ready = 1'b0;
        check("dropped_sticky", word_dropped, 1'b1);

        // Frequency violation with a tick in WORD_HELD
        send_bits(8'h5A);
        pause_start();
        short_pause();
        fv = 1'b1; data_i = 1'b1; tick = 1'b1;
        step();
        fv = 1'b0; data_i = 1'b0; tick = 1'b0;
        check("viol_state", rx_state, ST_ERROR);
        check("viol_cnt", err_cnt, 8'd2);
        repeat (3) step();
        check("viol_nopush", word_valid, 1'b0);
        long_pause();

        // clk_en low freezes the receiver
        clk_en = 1'b0;
        send_tick(1'b1);
        check("clken_hold", rx_state, ST_IDLE);
        clk_en = 1'b1;

        // Reset mid-word with clk_en low, buffer holding a word
        frame(8'h77, 1'b0);
        repeat (3) step();
        send_tick(1'b1); send_tick(1'b0); send_tick(1'b1);
        clk_en = 1'b0; sync_rst_n = 1'b0;
        step();
        sync_rst_n = 1'b1; clk_en = 1'b1;
        check("mrst_state", rx_state, ST_UNSYNCED);
        check("mrst_valid", word_valid, 1'b0);
        check("mrst_data", word_data, 8'h00);
        check("mrst_last", word_last, 1'b0);
        check("mrst_dropped", word_dropped, 1'b0);
        check("mrst_errcnt", err_cnt, 8'h00);
        repeat (4) step();
        check("mrst_nopush", word_valid, 1'b0);

        // Push into a full buffer coinciding with a pop
        long_pause();
        frame(8'h01, 1'b1);
        frame(8'h02, 1'b1);
        frame(8'h03, 1'b1);
        frame(8'h04, 1'b1);
        repeat (2) step();
        frame(8'h05, 1'b1);
        word_ready = 1'b1;
        drain(20);
        check("full_pushpop_nodrop", word_dropped, 1'b0);
        word_ready = 1'b0;

        // Receiver disable mid-word forces UNSYNCED and clears the word
        send_tick(1'b1); send_tick(1'b1); send_tick(1'b1);
        rec_en = 1'b0;
        step();
        check("disable_state", rx_state, ST_UNSYNCED);
        rec_en = 1'b1;
        long_pause();
        frame(8'hC3, 1'b1);
        drain(20);

        // Error counter saturation
        for (int i = 0; i < 256; i++) begin
            send_tick(1'b0);
            pause_start();
            long_pause();
            if (i == 254) check("errcnt_255", err_cnt, 8'd255);
        end
        check("errcnt_saturated", err_cnt, 8'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
